// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control unit: ALU opcodes, funct codes,
// main-control alu_op codes, FSM states and the decoder result struct.
package alu_ctrl_pkg;

   localparam logic [3:0] ALU_NOP = 4'b0000;
   localparam logic [3:0] ALU_ADD = 4'b0001;
   localparam logic [3:0] ALU_SUB = 4'b0010;
   localparam logic [3:0] ALU_MUL = 4'b0011;
   localparam logic [3:0] ALU_AND = 4'b0100;
   localparam logic [3:0] ALU_OR  = 4'b0101;
   localparam logic [3:0] ALU_SRL = 4'b0110;
   localparam logic [3:0] ALU_SLL = 4'b0111;
   localparam logic [3:0] ALU_NOT = 4'b1000;
   localparam logic [3:0] ALU_SRA = 4'b1001;
   localparam logic [3:0] ALU_SLA = 4'b1010;
   localparam logic [3:0] ALU_NEG = 4'b1011;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_MUL = 6'b011000;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SRL = 6'b000010;
   localparam logic [5:0] FUNCT_SLL = 6'b000000;
   localparam logic [5:0] FUNCT_NOP = 6'b101010;
   localparam logic [5:0] FUNCT_SRA = 6'b000011;
   localparam logic [5:0] FUNCT_SLA = 6'b000001;
   localparam logic [5:0] FUNCT_NOT = 6'b100111;
   localparam logic [5:0] FUNCT_NEG = 6'b100011;

   localparam logic [1:0] ALUOP_JUMP   = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
   localparam logic [1:0] ALUOP_ADDI   = 2'b11;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_MWAIT = 1'b1
   } state_e;

   typedef struct packed {
      logic [3:0] op;
      logic       is_mul;
      logic       illegal;
   } dec_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Purely combinational {alu_op, funct} -> {ALU opcode, is_mul, illegal} table.
// Extended shift/NOT/NEG codes decode only when EXT_OPS is set.
module alu_ctrl_decode
   import alu_ctrl_pkg::*;
#(
   parameter int ALUOP_W = 2,
   parameter int FUNCT_W = 6,
   parameter int EXT_OPS = 1
) (
   input  logic [ALUOP_W-1:0] alu_op_i,
   input  logic [FUNCT_W-1:0] funct_i,
   output dec_t               dec_o
);

   localparam logic EXT_EN = (EXT_OPS != 0);

   always_comb begin
      dec_o = '{op: ALU_NOP, is_mul: 1'b0, illegal: 1'b0};
      if (alu_op_i == ALUOP_W'(ALUOP_ADDI) || alu_op_i == ALUOP_W'(ALUOP_JUMP)) begin
         dec_o.op = ALU_ADD;
      end else if (alu_op_i == ALUOP_W'(ALUOP_BRANCH)) begin
         dec_o.op = ALU_SUB;
      end else if (alu_op_i == ALUOP_W'(ALUOP_RTYPE)) begin
         case (funct_i)
            FUNCT_W'(FUNCT_ADD): dec_o.op = ALU_ADD;
            FUNCT_W'(FUNCT_SUB): dec_o.op = ALU_SUB;
            FUNCT_W'(FUNCT_MUL): begin
               dec_o.op     = ALU_MUL;
               dec_o.is_mul = 1'b1;
            end
            FUNCT_W'(FUNCT_AND): dec_o.op = ALU_AND;
            FUNCT_W'(FUNCT_OR):  dec_o.op = ALU_OR;
            FUNCT_W'(FUNCT_SRL): dec_o.op = ALU_SRL;
            FUNCT_W'(FUNCT_SLL): dec_o.op = ALU_SLL;
            FUNCT_W'(FUNCT_NOP): dec_o.op = ALU_NOP;
            // Extended codes fall back to the illegal path when disabled.
            FUNCT_W'(FUNCT_SRA): if (EXT_EN) dec_o.op = ALU_SRA; else dec_o.illegal = 1'b1;
            FUNCT_W'(FUNCT_SLA): if (EXT_EN) dec_o.op = ALU_SLA; else dec_o.illegal = 1'b1;
            FUNCT_W'(FUNCT_NOT): if (EXT_EN) dec_o.op = ALU_NOT; else dec_o.illegal = 1'b1;
            FUNCT_W'(FUNCT_NEG): if (EXT_EN) dec_o.op = ALU_NEG; else dec_o.illegal = 1'b1;
            default:             dec_o.illegal = 1'b1;
         endcase
      end else begin
         dec_o.illegal = 1'b1;
      end
   end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control unit: decodes one op per accept, stalls issue for
// MUL_CYCLES-1 cycles after a MULTIPLY, and drops pending work on flush.
module alu_ctrl_seq
   import alu_ctrl_pkg::*;
#(
   parameter int ALUOP_W    = 2,
   parameter int FUNCT_W    = 6,
   parameter int OP_W       = 4,
   parameter int MUL_CYCLES = 4,
   parameter int EXT_OPS    = 1
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               flush_i,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic [ALUOP_W-1:0] alu_op_i,
   input  logic [FUNCT_W-1:0] funct_i,
   output logic [OP_W-1:0]    operation_o,
   output logic               op_valid_o,
   output logic               mul_start_o,
   output logic               illegal_o
);

   localparam int             CNT_W    = $clog2(MUL_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic           MUL_STALL = (MUL_CYCLES > 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [OP_W-1:0]   operation_q, operation_d;
   logic              op_valid_q, op_valid_d;
   logic              mul_start_q, mul_start_d;
   logic              illegal_q, illegal_d;
   dec_t              dec;
   logic              accept;

   alu_ctrl_decode #(
      .ALUOP_W (ALUOP_W),
      .FUNCT_W (FUNCT_W),
      .EXT_OPS (EXT_OPS)
   ) u_decode (
      .alu_op_i (alu_op_i),
      .funct_i  (funct_i),
      .dec_o    (dec)
   );

   // Handshake: a transfer happens when in_valid_i and in_ready_o are both high
   // in the same cycle; in_ready_o is low during reset, flush and the MUL stall.
   assign in_ready_o = ~reset_i & ~flush_i & (state_q == ST_IDLE);
   assign accept     = in_valid_i & in_ready_o;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      operation_d = operation_q;
      op_valid_d  = 1'b0;
      mul_start_d = 1'b0;
      illegal_d   = 1'b0;
      if (flush_i) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  operation_d = OP_W'(dec.op);
                  op_valid_d  = 1'b1;
                  mul_start_d = dec.is_mul;
                  illegal_d   = dec.illegal;
                  if (dec.is_mul && MUL_STALL) begin
                     state_d = ST_MWAIT;
                     cnt_d   = CNT_LOAD;
                  end
               end
            end
            ST_MWAIT: begin
               // Counter lands on zero as the FSM returns to IDLE, so it never wraps.
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == CNT_ONE) state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         operation_q <= '0;
         op_valid_q  <= 1'b0;
         mul_start_q <= 1'b0;
         illegal_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         operation_q <= operation_d;
         op_valid_q  <= op_valid_d;
         mul_start_q <= mul_start_d;
         illegal_q   <= illegal_d;
      end
   end

   assign operation_o = operation_q;
   assign op_valid_o  = op_valid_q;
   assign mul_start_o = mul_start_q;
   assign illegal_o   = illegal_q;

endmodule
